atomrvcore_decode_stage: RTL and testbench

//  Registered RV32 decode stage between fetch and execute, with valid/ready handshakes on both sides.

---
 rtl/atomrvcore_pkg.sv | 47 ++++
 rtl/atomrvcore_decode_stage_if.sv | 42 ++++
 rtl/atomrvcore_imm_gen.sv | 26 ++
 rtl/atomrvcore_decode_stage.sv | 116 +++++++++++
 tb/tb_atomrvcore_decode_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/atomrvcore_pkg.sv
// Shared RV32 decode types: instruction formats, opcode table and the
// control part of a decoded bundle.
package atomrvcore_pkg;

  typedef enum logic [2:0] {
    IT_R,
    IT_I,
    IT_S,
    IT_B,
    IT_U,
    IT_J,
    IT_ILLEGAL
  } instr_type_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    instr_type_t instr_type;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

  function automatic instr_type_t opcode_type(input logic [6:0] opc);
    case (opc)
      OPC_OP:                                   return IT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: return IT_I;
      OPC_STORE:                                return IT_S;
      OPC_BRANCH:                               return IT_B;
      OPC_LUI, OPC_AUIPC:                       return IT_U;
      OPC_JAL:                                  return IT_J;
      default:                                  return IT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/atomrvcore_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface atomrvcore_decode_stage_if
  import atomrvcore_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  valid_i;
  logic                  ready_o;
  logic [31:0]           instr_i;
  logic [XLEN-1:0]       rs1_data_i;
  logic [XLEN-1:0]       rs2_data_i;
  logic                  valid_o;
  logic                  ready_i;
  instr_type_t           instr_type_o;
  logic [6:0]            opcode_o;
  logic [2:0]            func3_o;
  logic [6:0]            func7_o;
  logic [REG_ADDR_W-1:0] rs1_o;
  logic [REG_ADDR_W-1:0] rs2_o;
  logic [REG_ADDR_W-1:0] rd_o;
  logic                  rd_we_o;
  logic [XLEN-1:0]       imm_o;
  logic [XLEN-1:0]       operand_a_o;
  logic [XLEN-1:0]       operand_b_o;
  logic [XLEN-1:0]       mem_addr_o;
  logic                  illegal_o;

  modport master (
    output valid_i, instr_i, rs1_data_i, rs2_data_i, ready_i,
    input  ready_o, valid_o, instr_type_o, opcode_o, func3_o, func7_o,
           rs1_o, rs2_o, rd_o, rd_we_o, imm_o, operand_a_o, operand_b_o,
           mem_addr_o, illegal_o
  );

  modport slave (
    input  valid_i, instr_i, rs1_data_i, rs2_data_i, ready_i,
    output ready_o, valid_o, instr_type_o, opcode_o, func3_o, func7_o,
           rs1_o, rs2_o, rd_o, rd_we_o, imm_o, operand_a_o, operand_b_o,
           mem_addr_o, illegal_o
  );
endinterface

// File: rtl/atomrvcore_imm_gen.sv
// Combinational immediate extraction for every RV32 format, sign-extended to XLEN.
module atomrvcore_imm_gen
  import atomrvcore_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  instr_type_t     instr_type,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr_type)
      IT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IT_U: imm32 = {instr[31:12], 12'b0};
      IT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/atomrvcore_decode_stage.sv
// Registered RV32 decode stage: combinational decode into an output entry,
// with an optional skid entry absorbing execute-side backpressure.
module atomrvcore_decode_stage
  import atomrvcore_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          SKID_EN    = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  atomrvcore_decode_stage_if.slave   bus
);
  typedef struct packed {
    decoded_t              ctrl;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [XLEN-1:0]       mem_addr;
  } entry_t;

  entry_t          dec, out_q, skid_q;
  logic            valid_q, skid_valid_q;
  logic            out_free, in_fire;
  instr_type_t     dec_type;
  logic [XLEN-1:0] dec_imm;
  logic [31:0]     instr;

  assign instr    = bus.instr_i;
  assign dec_type = opcode_type(instr[6:0]);

  atomrvcore_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr      (instr),
    .instr_type (dec_type),
    .imm        (dec_imm)
  );

  always_comb begin
    dec                 = '0;
    dec.ctrl.instr_type = dec_type;
    dec.ctrl.opcode     = instr[6:0];
    dec.ctrl.illegal    = (dec_type == IT_ILLEGAL);
    dec.imm             = dec_imm;
    dec.operand_a       = bus.rs1_data_i;
    case (dec_type)
      IT_R, IT_I: begin
        dec.rd         = REG_ADDR_W'(instr[11:7]);
        dec.rs1        = REG_ADDR_W'(instr[19:15]);
        dec.ctrl.func3 = instr[14:12];
        dec.ctrl.func7 = instr[31:25];
        if (dec_type == IT_R) dec.rs2 = REG_ADDR_W'(instr[24:20]);
      end
      IT_S, IT_B: begin
        dec.rs1        = REG_ADDR_W'(instr[19:15]);
        dec.rs2        = REG_ADDR_W'(instr[24:20]);
        dec.ctrl.func3 = instr[14:12];
      end
      IT_U, IT_J: dec.rd = REG_ADDR_W'(instr[11:7]);
      default: ;
    endcase
    // rd is already zero for formats without a destination
    dec.ctrl.rd_we = (dec.rd != '0);
    dec.operand_b  = (dec_type == IT_R || dec_type == IT_B) ? bus.rs2_data_i : dec_imm;
    if (instr[6:0] == OPC_LOAD || instr[6:0] == OPC_STORE)
      dec.mem_addr = bus.rs1_data_i + dec_imm;
  end

  assign out_free    = !valid_q || bus.ready_i;
  assign bus.ready_o = SKID_EN ? !skid_valid_q : out_free;
  assign in_fire     = bus.valid_i && bus.ready_o;

  // Skid drains before new input; ready_o is low while skid is full, so the
  // drain cycle never coincides with an accepted input.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        valid_q      <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        valid_q <= in_fire;
        if (in_fire) out_q <= dec;
      end
    end else if (in_fire) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.instr_type_o = out_q.ctrl.instr_type;
  assign bus.opcode_o     = out_q.ctrl.opcode;
  assign bus.func3_o      = out_q.ctrl.func3;
  assign bus.func7_o      = out_q.ctrl.func7;
  assign bus.rd_we_o      = out_q.ctrl.rd_we;
  assign bus.illegal_o    = out_q.ctrl.illegal;
  assign bus.rs1_o        = out_q.rs1;
  assign bus.rs2_o        = out_q.rs2;
  assign bus.rd_o         = out_q.rd;
  assign bus.imm_o        = out_q.imm;
  assign bus.operand_a_o  = out_q.operand_a;
  assign bus.operand_b_o  = out_q.operand_b;
  assign bus.mem_addr_o   = out_q.mem_addr;
endmodule

// File: tb/tb_atomrvcore_decode_stage.sv
// Directed bench for the decode stage: decode vectors, skid ordering, flush and reset.
module tb_atomrvcore_decode_stage;
  import atomrvcore_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  atomrvcore_decode_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  atomrvcore_decode_stage #(.XLEN(32), .REG_ADDR_W(5), .SKID_EN(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic present(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i    = v;
    bus.instr_i    = ins;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    bus.ready_i = 1'b0;
    present(1'b0, 32'h0, 32'h0, 32'h0);
    step(); step();
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_imm", 64'(bus.imm_o), 64'd0);
    chk("rst_type", 64'(bus.instr_type_o), 64'd0);
    chk("rst_rd", 64'(bus.rd_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);

    // Back-to-back decode vectors with ready_i=1
    rst_n = 1'b1; bus.ready_i = 1'b1;
    present(1'b1, 32'hFFF10093, 32'h11, 32'h22);           // ADDI x1,x2,-1
    step();
    chk("addi_valid", 64'(bus.valid_o), 64'd1);
    chk("addi_type", 64'(bus.instr_type_o), 64'(IT_I));
    chk("addi_rd", 64'(bus.rd_o), 64'd1);
    chk("addi_rs1", 64'(bus.rs1_o), 64'd2);
    chk("addi_rs2", 64'(bus.rs2_o), 64'd0);
    chk("addi_imm", 64'(bus.imm_o), 64'hFFFFFFFF);
    chk("addi_we", 64'(bus.rd_we_o), 64'd1);
    chk("addi_f7", 64'(bus.func7_o), 64'h7F);
    chk("addi_opa", 64'(bus.operand_a_o), 64'h11);
    chk("addi_opb", 64'(bus.operand_b_o), 64'hFFFFFFFF);
    chk("addi_mem", 64'(bus.mem_addr_o), 64'd0);

    present(1'b1, 32'h00532423, 32'h100, 32'hDEAD);        // SW x5,8(x6)
    step();
    chk("sw_valid", 64'(bus.valid_o), 64'd1);
    chk("sw_type", 64'(bus.instr_type_o), 64'(IT_S));
    chk("sw_imm", 64'(bus.imm_o), 64'd8);
    chk("sw_mem", 64'(bus.mem_addr_o), 64'h108);
    chk("sw_we", 64'(bus.rd_we_o), 64'd0);
    chk("sw_rd", 64'(bus.rd_o), 64'd0);
    chk("sw_rs2", 64'(bus.rs2_o), 64'd5);
    chk("sw_opb", 64'(bus.operand_b_o), 64'd8);
    chk("sw_f3", 64'(bus.func3_o), 64'd2);

    present(1'b1, 32'h00208463, 32'h5, 32'h77);            // BEQ x1,x2,8
    step();
    chk("beq_type", 64'(bus.instr_type_o), 64'(IT_B));
    chk("beq_imm", 64'(bus.imm_o), 64'd8);
    chk("beq_opb", 64'(bus.operand_b_o), 64'h77);
    chk("beq_we", 64'(bus.rd_we_o), 64'd0);

    present(1'b1, 32'h123451B7, 32'h0, 32'h0);             // LUI x3,0x12345
    step();
    chk("lui_type", 64'(bus.instr_type_o), 64'(IT_U));
    chk("lui_imm", 64'(bus.imm_o), 64'h12345000);
    chk("lui_rd", 64'(bus.rd_o), 64'd3);
    chk("lui_f3", 64'(bus.func3_o), 64'd0);

    present(1'b1, 32'h0010006F, 32'h0, 32'h0);             // JAL x0,+2048
    step();
    chk("jal_type", 64'(bus.instr_type_o), 64'(IT_J));
    chk("jal_imm", 64'(bus.imm_o), 64'h800);
    chk("jal_we_x0", 64'(bus.rd_we_o), 64'd0);

    present(1'b1, 32'hFFC12083, 32'h2, 32'h0);             // LW x1,-4(x2): address wraps
    step();
    chk("lw_mem_wrap", 64'(bus.mem_addr_o), 64'hFFFFFFFE);
    chk("lw_imm", 64'(bus.imm_o), 64'hFFFFFFFC);

    present(1'b1, 32'hFFFFFFFF, 32'h0, 32'h0);             // opcode 0x7F
    step();
    chk("ill_flag", 64'(bus.illegal_o), 64'd1);
    chk("ill_valid", 64'(bus.valid_o), 64'd1);
    chk("ill_type", 64'(bus.instr_type_o), 64'(IT_ILLEGAL));
    chk("ill_we", 64'(bus.rd_we_o), 64'd0);
    chk("ill_imm", 64'(bus.imm_o), 64'd0);
    chk("ill_rd", 64'(bus.rd_o), 64'd0);

    present(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk("idle_valid", 64'(bus.valid_o), 64'd0);

    // Skid: A held, B into skid, C waits; then release
    bus.ready_i = 1'b0;
    present(1'b1, 32'h00100093, 32'h0, 32'h0);             // A: ADDI x1,x0,1
    step();
    chk("skA_valid", 64'(bus.valid_o), 64'd1);
    chk("skA_imm", 64'(bus.imm_o), 64'd1);
    chk("skA_ready", 64'(bus.ready_o), 64'd1);
    present(1'b1, 32'h00200113, 32'h0, 32'h0);             // B: ADDI x2,x0,2
    step();
    chk("skB_hold", 64'(bus.imm_o), 64'd1);
    chk("skB_ready", 64'(bus.ready_o), 64'd0);
    present(1'b1, 32'h00300193, 32'h0, 32'h0);             // C: ADDI x3,x0,3
    step();
    chk("skC_hold", 64'(bus.imm_o), 64'd1);
    chk("skC_ready", 64'(bus.ready_o), 64'd0);
    bus.ready_i = 1'b1;
    step();
    chk("rel_B_valid", 64'(bus.valid_o), 64'd1);
    chk("rel_B_imm", 64'(bus.imm_o), 64'd2);
    chk("rel_B_rd", 64'(bus.rd_o), 64'd2);
    chk("rel_C_ready", 64'(bus.ready_o), 64'd1);
    step();
    present(1'b0, 32'h0, 32'h0, 32'h0);
    chk("rel_C_valid", 64'(bus.valid_o), 64'd1);
    chk("rel_C_imm", 64'(bus.imm_o), 64'd3);
    step();
    chk("rel_drain", 64'(bus.valid_o), 64'd0);

    // Flush with A held, B in skid, C presented
    bus.ready_i = 1'b0;
    present(1'b1, 32'h00100093, 32'h0, 32'h0);
    step();
    present(1'b1, 32'h00200113, 32'h0, 32'h0);
    step();
    present(1'b1, 32'h00300193, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    present(1'b0, 32'h0, 32'h0, 32'h0);
    bus.ready_i = 1'b1;
    chk("fl_valid", 64'(bus.valid_o), 64'd0);
    chk("fl_ready", 64'(bus.ready_o), 64'd1);
    step();
    chk("fl_valid2", 64'(bus.valid_o), 64'd0);

    // Input handshaking in the flush cycle is discarded
    present(1'b1, 32'h00500293, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    present(1'b0, 32'h0, 32'h0, 32'h0);
    chk("fl_in_drop", 64'(bus.valid_o), 64'd0);

    // Reset while stalled with skid full
    bus.ready_i = 1'b0;
    present(1'b1, 32'h00100093, 32'h0, 32'h0);
    step();
    present(1'b1, 32'h00200113, 32'h0, 32'h0);
    step();
    rst_n = 1'b0;
    present(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk("rs_valid", 64'(bus.valid_o), 64'd0);
    chk("rs_imm", 64'(bus.imm_o), 64'd0);
    chk("rs_rd", 64'(bus.rd_o), 64'd0);
    chk("rs_ready", 64'(bus.ready_o), 64'd1);
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    present(1'b1, 32'h123451B7, 32'h0, 32'h0);
    step();
    present(1'b0, 32'h0, 32'h0, 32'h0);
    chk("post_valid", 64'(bus.valid_o), 64'd1);
    chk("post_imm", 64'(bus.imm_o), 64'h12345000);
    step();
    chk("post_drain", 64'(bus.valid_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
